// File: rtl/ili9341_8080_rx.sv
// ILI9341 8080-I 8-bit write-bus responder: decodes commands/params, tracks the
// CASET/PASET window and turns RAMWR byte pairs into RGB565 framebuffer writes.
module ili9341_8080_rx #(
  parameter int COLS   = 240,
  parameter int ROWS   = 320,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        tftParallelPort,
  input  logic              tftChipSelect,
  input  logic              tftWriteEnable,
  input  logic              tftDataCmd,
  input  logic              tftReset,
  output logic              cmdStrobe,
  output logic [7:0]        cmdByte,
  output logic              paramStrobe,
  output logic [7:0]        paramByte,
  output logic              frameStart,
  output logic              pixWrEn,
  output logic [ADDR_W-1:0] pixAddr,
  output logic [15:0]       pixData
);

  typedef enum logic [1:0] {IDLE, CASET_P, PASET_P, RAMWR} state_t;

  typedef struct packed {
    state_t            state;
    logic [15:0]       sc, ec, sp, ep;
    logic [15:0]       col, page;
    logic [2:0]        pidx;
    logic              half;
    logic [7:0]        hi;
    logic              cmd_stb;
    logic [7:0]        cmd_b;
    logic              par_stb;
    logic [7:0]        par_b;
    logic              frame;
    logic              pix_we;
    logic [15:0]       pix_d;
    logic [ADDR_W-1:0] pix_a;
  } rx_t;

  // Equal-depth synchronizers; index [1] is the synchronized value.
  logic [1:0][7:0] d_sq;
  logic [1:0]      cs_sq, wr_sq, dc_sq, rs_sq;
  logic            wr_prev_q, cs_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_sq      <= '0;
      cs_sq     <= '1;
      wr_sq     <= '1;
      dc_sq     <= '0;
      rs_sq     <= '0;
      wr_prev_q <= 1'b1;
      cs_prev_q <= 1'b1;
    end else begin
      d_sq      <= {d_sq[0], tftParallelPort};
      cs_sq     <= {cs_sq[0], tftChipSelect};
      wr_sq     <= {wr_sq[0], tftWriteEnable};
      dc_sq     <= {dc_sq[0], tftDataCmd};
      rs_sq     <= {rs_sq[0], tftReset};
      wr_prev_q <= wr_sq[1];
      cs_prev_q <= cs_sq[1];
    end
  end

  logic soft_rst;
  assign soft_rst = ~rs_sq[1];

  // One registered event stage so strobes land exactly one cycle after edge N+3.
  logic       ev_q, ev_dc_q, csr_q;
  logic [7:0] ev_b_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ev_q    <= 1'b0;
      ev_dc_q <= 1'b0;
      ev_b_q  <= '0;
      csr_q   <= 1'b0;
    end else if (soft_rst) begin
      ev_q    <= 1'b0;
      ev_dc_q <= 1'b0;
      ev_b_q  <= '0;
      csr_q   <= 1'b0;
    end else begin
      ev_q    <= wr_sq[1] & ~wr_prev_q & ~cs_sq[1];
      ev_dc_q <= dc_sq[1];
      ev_b_q  <= d_sq[1];
      csr_q   <= cs_sq[1] & ~cs_prev_q;
    end
  end

  rx_t               st_q;
  logic [15:0]       col_d, page_d;
  logic              in_win;
  logic [ADDR_W-1:0] addr_d;
  logic              caset;

  // Pointer advance compares the current column against EC before stepping.
  always_comb begin
    col_d  = st_q.col + 16'd1;
    page_d = st_q.page;
    if (st_q.col == st_q.ec) begin
      col_d  = st_q.sc;
      page_d = (st_q.page == st_q.ep) ? st_q.sp : st_q.page + 16'd1;
    end
    in_win = (32'(st_q.col) < 32'(COLS)) && (32'(st_q.page) < 32'(ROWS));
    addr_d = ADDR_W'(32'(st_q.page) * 32'(COLS) + 32'(st_q.col));
    caset  = (st_q.state == CASET_P);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= '0;
      st_q.ec <= 16'(COLS - 1);
      st_q.ep <= 16'(ROWS - 1);
    end else if (soft_rst) begin
      st_q    <= '0;
      st_q.ec <= 16'(COLS - 1);
      st_q.ep <= 16'(ROWS - 1);
    end else begin
      st_q.cmd_stb <= 1'b0;
      st_q.par_stb <= 1'b0;
      st_q.frame   <= 1'b0;
      st_q.pix_we  <= 1'b0;
      if (ev_q) begin
        if (!ev_dc_q) begin
          st_q.cmd_stb <= 1'b1;
          st_q.cmd_b   <= ev_b_q;
          st_q.pidx    <= '0;
          st_q.half    <= 1'b0;
          case (ev_b_q)
            8'h2A:   st_q.state <= CASET_P;
            8'h2B:   st_q.state <= PASET_P;
            8'h2C: begin
              st_q.state <= RAMWR;
              st_q.frame <= 1'b1;
              st_q.col   <= st_q.sc;
              st_q.page  <= st_q.sp;
            end
            default: st_q.state <= IDLE;
          endcase
        end else if (st_q.state == RAMWR) begin
          if (!st_q.half) begin
            st_q.hi   <= ev_b_q;
            st_q.half <= 1'b1;
          end else begin
            st_q.half <= 1'b0;
            st_q.col  <= col_d;
            st_q.page <= page_d;
            if (in_win) begin
              st_q.pix_we <= 1'b1;
              st_q.pix_d  <= {st_q.hi, ev_b_q};
              st_q.pix_a  <= addr_d;
            end
          end
        end else begin
          st_q.par_stb <= 1'b1;
          st_q.par_b   <= ev_b_q;
          if (st_q.pidx != 3'd4) st_q.pidx <= st_q.pidx + 3'd1;
          if (st_q.state != IDLE) begin
            case (st_q.pidx)
              3'd0: if (caset) st_q.sc[15:8] <= ev_b_q; else st_q.sp[15:8] <= ev_b_q;
              3'd1: if (caset) st_q.sc[7:0]  <= ev_b_q; else st_q.sp[7:0]  <= ev_b_q;
              3'd2: if (caset) st_q.ec[15:8] <= ev_b_q; else st_q.ep[15:8] <= ev_b_q;
              3'd3: if (caset) st_q.ec[7:0]  <= ev_b_q; else st_q.ep[7:0]  <= ev_b_q;
              default: ;
            endcase
          end
        end
      end else if (csr_q) begin
        st_q.half <= 1'b0;
      end
    end
  end

  assign cmdStrobe   = st_q.cmd_stb;
  assign cmdByte     = st_q.cmd_b;
  assign paramStrobe = st_q.par_stb;
  assign paramByte   = st_q.par_b;
  assign frameStart  = st_q.frame;
  assign pixWrEn     = st_q.pix_we;
  assign pixData     = st_q.pix_d;
  assign pixAddr     = st_q.pix_a;

endmodule

// File: tb/tb_ili9341_8080_rx.sv
// Bench for ili9341_8080_rx: directed vector table, corner sequences and a
// randomized byte stream checked against a byte-level model of the panel.
module tb_ili9341_8080_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  D = '0;
  logic        CS = 1'b0, WRX = 1'b1, DC = 1'b0, RESX = 1'b1;
  logic        cmdStrobe, paramStrobe, frameStart, pixWrEn;
  logic [7:0]  cmdByte, paramByte;
  logic [15:0] pixData;
  logic [16:0] pixAddr;

  always #5 clk = ~clk;

  ili9341_8080_rx dut (
    .clk(clk), .reset(reset), .tftParallelPort(D), .tftChipSelect(CS),
    .tftWriteEnable(WRX), .tftDataCmd(DC), .tftReset(RESX),
    .cmdStrobe(cmdStrobe), .cmdByte(cmdByte), .paramStrobe(paramStrobe),
    .paramByte(paramByte), .frameStart(frameStart), .pixWrEn(pixWrEn),
    .pixAddr(pixAddr), .pixData(pixData)
  );

  typedef struct packed {
    logic [3:0]  stb;   // {cmd, param, frame, pix}
    logic [7:0]  cmdB;
    logic [7:0]  parB;
    logic [15:0] pixD;
    logic [16:0] pixA;
  } obs_t;

  typedef struct {
    bit          dc;
    logic [7:0]  b;
    logic [3:0]  stb;
    logic [15:0] data;
    logic [16:0] addr;
  } vec_t;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  function automatic obs_t cur();
    return '{stb: {cmdStrobe, paramStrobe, frameStart, pixWrEn}, cmdB: cmdByte,
             parB: paramByte, pixD: pixData, pixA: pixAddr};
  endfunction

  // Byte-level model: mode is simply the last command byte seen.
  logic [7:0]  m_last;
  int          m_pidx;
  logic [15:0] m_win[4];  // SC, EC, SP, EP
  logic [15:0] m_col, m_page;
  bit          m_half;
  logic [7:0]  m_hi;
  obs_t        m_o;

  function automatic void m_reset();
    m_last = 8'h00; m_pidx = 0; m_half = 0; m_hi = 0;
    m_win[0] = 0; m_win[1] = 239; m_win[2] = 0; m_win[3] = 319;
    m_col = 0; m_page = 0; m_o = '0;
  endfunction

  function automatic obs_t model(bit dc, logic [7:0] b);
    int base;
    m_o.stb = 4'b0000;
    if (!dc) begin
      m_o.stb[3] = 1; m_o.cmdB = b; m_last = b; m_pidx = 0; m_half = 0;
      if (b == 8'h2C) begin
        m_o.stb[1] = 1; m_col = m_win[0]; m_page = m_win[2];
      end
    end else if (m_last == 8'h2C) begin
      if (!m_half) begin
        m_hi = b; m_half = 1;
      end else begin
        m_half = 0;
        if (m_col < 240 && m_page < 320) begin
          m_o.stb[0] = 1; m_o.pixD = {m_hi, b};
          m_o.pixA = 17'(int'(m_page) * 240 + int'(m_col));
        end
        if (m_col == m_win[1]) begin
          m_col = m_win[0];
          m_page = (m_page == m_win[3]) ? m_win[2] : m_page + 16'd1;
        end else m_col = m_col + 16'd1;
      end
    end else begin
      m_o.stb[2] = 1; m_o.parB = b;
      if ((m_last == 8'h2A || m_last == 8'h2B) && m_pidx < 4) begin
        base = (m_last == 8'h2B) ? 2 : 0;
        if (m_pidx[0]) m_win[base + m_pidx/2][7:0]  = b;
        else           m_win[base + m_pidx/2][15:8] = b;
      end
      m_pidx++;
    end
    return m_o;
  endfunction

  task automatic send(input bit dc, input logic [7:0] b, output obs_t got);
    obs_t exp;
    @(negedge clk); D = b; DC = dc; WRX = 0;
    repeat (3) @(negedge clk);
    WRX = 1;
    exp = model(dc, b);
    repeat (4) @(posedge clk);
    @(negedge clk);
    got = cur();
    chk("strobes", 64'(got.stb), 64'(exp.stb));
    chk("cmdByte", 64'(got.cmdB), 64'(exp.cmdB));
    chk("paramByte", 64'(got.parB), 64'(exp.parB));
    chk("pixData", 64'(got.pixD), 64'(exp.pixD));
    chk("pixAddr", 64'(got.pixA), 64'(exp.pixA));
    @(negedge clk);
    chk("pulse_width", 64'({cmdStrobe, paramStrobe, frameStart, pixWrEn}), 64'(0));
  endtask

  task automatic cs_toggle();
    @(negedge clk); CS = 1;
    repeat (5) @(negedge clk);
    CS = 0;
    m_half = 0;
    repeat (5) @(negedge clk);
  endtask

  vec_t tbl[$];
  task automatic add(input bit dc, input logic [7:0] b, input logic [3:0] stb,
                     input logic [15:0] data, input logic [16:0] addr);
    vec_t v;
    v.dc = dc; v.b = b; v.stb = stb; v.data = data; v.addr = addr;
    tbl.push_back(v);
  endtask

  initial begin
    obs_t g;
    int npix;
    logic [16:0] lastA;
    logic [16:0] paddr[5];
    paddr = '{17'd1210, 17'd1211, 17'd1450, 17'd1451, 17'd1210};

    add(0, 8'h2C, 4'b1010, 0, 0);
    add(1, 8'hF8, 4'b0000, 0, 0);
    add(1, 8'h00, 4'b0001, 16'hF800, 0);
    add(1, 8'h07, 4'b0000, 0, 0);
    add(1, 8'hE0, 4'b0001, 16'h07E0, 1);
    add(0, 8'h2A, 4'b1000, 0, 0);
    add(1, 8'h00, 4'b0100, 0, 0); add(1, 8'h0A, 4'b0100, 0, 0);
    add(1, 8'h00, 4'b0100, 0, 0); add(1, 8'h0B, 4'b0100, 0, 0);
    add(0, 8'h2B, 4'b1000, 0, 0);
    add(1, 8'h00, 4'b0100, 0, 0); add(1, 8'h05, 4'b0100, 0, 0);
    add(1, 8'h00, 4'b0100, 0, 0); add(1, 8'h06, 4'b0100, 0, 0);
    add(0, 8'h2C, 4'b1010, 0, 0);
    for (int k = 0; k < 5; k++) begin
      add(1, 8'hA0, 4'b0000, 0, 0);
      add(1, 8'(k), 4'b0001, 16'hA000 + 16'(k), paddr[k]);
    end
    add(0, 8'h36, 4'b1000, 0, 0);
    add(1, 8'h48, 4'b0100, 0, 0);

    // Reset state
    m_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(cur()), 64'(0));
    reset = 0;
    repeat (6) @(negedge clk);
    chk("post_reset_outputs", 64'(cur()), 64'(0));

    // Directed table
    foreach (tbl[i]) begin
      send(tbl[i].dc, tbl[i].b, g);
      chk("tbl_stb", 64'(g.stb), 64'(tbl[i].stb));
      if (tbl[i].stb[0]) begin
        chk("tbl_data", 64'(g.pixD), 64'(tbl[i].data));
        chk("tbl_addr", 64'(g.pixA), 64'(tbl[i].addr));
      end
    end

    // Async reset mid-byte: outputs drop at once
    @(negedge clk); D = 8'h55; DC = 1; WRX = 0;
    @(negedge clk); #2 reset = 1;
    #1 chk("async_reset_outputs", 64'(cur()), 64'(0));
    WRX = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    m_reset();
    repeat (6) @(negedge clk);
    chk("async_reset_quiet", 64'(cur()), 64'(0));

    // CSX deassert mid-pixel drops the lone byte
    send(0, 8'h2C, g);
    send(1, 8'h01, g); send(1, 8'h02, g);
    chk("cs_first_pix", 64'({g.stb[0], g.pixD, g.pixA}), 64'({1'b1, 16'h0102, 17'd0}));
    send(1, 8'h03, g);
    cs_toggle();
    send(1, 8'h12, g); send(1, 8'h34, g);
    chk("cs_second_pix", 64'({g.stb[0], g.pixD, g.pixA}), 64'({1'b1, 16'h1234, 17'd1}));

    // EC beyond COLS: 256 pixels, only 240 written, then next row
    send(0, 8'h2A, g);
    send(1, 8'h00, g); send(1, 8'h00, g); send(1, 8'h00, g); send(1, 8'hFF, g);
    send(0, 8'h2C, g);
    npix = 0; lastA = '0;
    for (int k = 0; k < 256; k++) begin
      send(1, 8'($urandom), g);
      send(1, 8'($urandom), g);
      if (g.stb[0]) begin npix++; lastA = g.pixA; end
    end
    chk("wide_ec_count", 64'(npix), 64'(240));
    chk("wide_ec_last", 64'(lastA), 64'(239));
    send(1, 8'hAB, g); send(1, 8'hCD, g);
    chk("wide_ec_wrap", 64'({g.stb[0], g.pixA}), 64'({1'b1, 17'd240}));

    // RESX low mid-RAMWR with a shrunk window
    send(0, 8'h2A, g);
    send(1, 8'h00, g); send(1, 8'h05, g); send(1, 8'h00, g); send(1, 8'h06, g);
    send(0, 8'h2C, g);
    send(1, 8'h77, g);
    @(negedge clk); RESX = 0;
    repeat (3) @(negedge clk);
    chk("resx_outputs", 64'(cur()), 64'(0));
    RESX = 1;
    m_reset();
    repeat (4) @(negedge clk);
    send(0, 8'h2C, g);
    send(1, 8'h11, g); send(1, 8'h22, g);
    chk("resx_window0", 64'({g.stb[0], g.pixA}), 64'({1'b1, 17'd0}));
    send(1, 8'h33, g); send(1, 8'h44, g);
    chk("resx_window1", 64'({g.stb[0], g.pixA}), 64'({1'b1, 17'd1}));

    // Randomized byte stream
    for (int k = 0; k < 400; k++) begin
      int r;
      logic [7:0] cmds[6];
      cmds = '{8'h2A, 8'h2B, 8'h2C, 8'h2C, 8'h36, 8'h00};
      cmds[5] = 8'($urandom);
      r = $urandom_range(0, 99);
      if (r < 3) cs_toggle();
      else if (r < 22) send(0, cmds[$urandom_range(0, 5)], g);
      else send(1, 8'($urandom), g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
